mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage front end placed between the EX/MEM pipeline register and the word-only data memory (256 x 32, word index addr[9:2]; writes on clk negedge; combinational read gated by MemRead).
- Adds byte, halfword and word loads/stores with sign or zero extension.
- Implements sub-word stores as a two-cycle read-modify-write (RMW), stalling the pipeline for one cycle.
- Detects misaligned or illegal requests, suppresses them, and records the faulting address.

Parameters:
COUNT_W, 16, width of rmw_cnt and fault_cnt (saturating counters).

Ports:
clk  input  1  pipeline clock; all state updates on posedge
reset  input  1  synchronous, active-high
req_read  input  1  load request from EX/MEM register
req_write  input  1  store request from EX/MEM register
req_size  input  2  00 byte, 01 half, 10 word, 11 illegal
req_unsigned  input  1  1 = zero-extend load (lbu/lhu), 0 = sign-extend
req_addr  input  32  byte address
req_wdata  input  32  store data, right-justified
flush  input  1  abort in-flight RMW
dm_MemRead  output  1  to data memory MemRead
dm_MemWrite  output  1  to data memory MemWrite
dm_addr  output  32  to data memory addr, always {req_addr[31:2],2'b00}
dm_writeData  output  32  to data memory writeData
dm_readData  input  32  from data memory readData
load_data  output  32  extended load result to MEM/WB
stall  output  1  hold PC, IF/ID, ID/EX, EX/MEM
misalign  output  1  fault pulse for the current request
bad_addr  output  32  address of the most recent fault
rmw_cnt  output  COUNT_W  completed RMW stores
fault_cnt  output  COUNT_W  faulted requests

Behaviour:
- Lane mapping is little-endian.
  - Byte lane k = addr[1:0] occupies bits [8k+7:8k].
  - Half lane h = addr[1] occupies bits [16h+15:16h].
- Reset values: state = IDLE, merge_reg = 0, bad_addr = 0, rmw_cnt = 0, fault_cnt = 0.
- While reset is high, dm_MemRead, dm_MemWrite, stall and misalign are 0.
- Fault condition (combinational) applies when (req_read|req_write) and any of:
  - req_read & req_write both asserted;
  - req_size == 11;
  - half with addr[0] = 1;
  - word with addr[1:0] != 0.
- On a fault:
  - misalign = 1; dm_MemRead = 0, dm_MemWrite = 0, stall = 0, load_data = 0.
  - At posedge: bad_addr <= req_addr; fault_cnt increments, saturating at all-ones.
- FSM has two states, IDLE and RMW_WR.
- IDLE, load, no fault:
  - dm_MemRead = 1.
  - load_data is the extracted lane, extended per req_unsigned, same cycle (combinational, zero latency).
  - Word load passes dm_readData through unchanged.
- IDLE, word store, no fault:
  - dm_MemWrite = 1 and dm_writeData = req_wdata in the same cycle; no stall.
- IDLE, byte/half store, no fault:
  - dm_MemRead = 1, dm_MemWrite = 0, stall = 1.
  - At posedge: merge_reg <= dm_readData with the target lane replaced by req_wdata[7:0] or req_wdata[15:0]; state <= RMW_WR.
- RMW_WR:
  - dm_MemWrite = 1, dm_writeData = merge_reg, dm_MemRead = 0, stall = 0.
  - At posedge: state <= IDLE; rmw_cnt increments, saturating.
  - The memory write lands on the negedge inside this cycle.
- Upstream holds all req_* inputs stable while stall = 1. The unit does not re-sample them; merge uses the held values.
- Flush:
  - flush in IDLE has no effect on combinational access.
  - flush in RMW_WR forces dm_MemWrite = 0 and state <= IDLE; rmw_cnt is not incremented and memory is unchanged.
- Reset asserted in RMW_WR: no write issued that cycle; all state returns to reset values.
- No request (req_read = req_write = 0): all dm_* strobes are 0 and load_data = 0.
- Back-to-back sub-word stores: the second one enters IDLE RMW read on the cycle after RMW_WR, giving one stall cycle per store.

Test Plan:
- Word store then load: store addr 0x10, data 0xDEADBEEF, then lw 0x10 -> dm_MemWrite pulse 1 cycle, no stall; load_data = 0xDEADBEEF.
- Byte store RMW: mem[0x20] = 0x11223344; sb addr 0x22, wdata 0xAB -> stall high exactly 1 cycle, then dm_writeData = 0x11AB3344, rmw_cnt = 1.
- Sign/zero extension: mem[0x30] = 0x80F0_7F01.
  - lb 0x32 -> 0xFFFFFFF0; lbu 0x32 -> 0x000000F0.
  - lh 0x32 -> 0xFFFF80F0; lhu 0x30 -> 0x00007F01.
- Misalignment: lw 0x41 -> misalign = 1, no dm strobes, bad_addr = 0x41, fault_cnt = 1; sh 0x43 -> bad_addr = 0x43, fault_cnt = 2, memory unchanged.
- Flush/reset mid-RMW: sh 0x50 with flush (or reset) asserted during RMW_WR -> dm_MemWrite stays 0, mem[0x50] unchanged, rmw_cnt unchanged, state IDLE next cycle.
- Back-to-back sb 0x60, 0x61, 0x62, 0x63 with data 0x01..0x04 -> 4 stall cycles; final mem[0x60] = 0x04030201, rmw_cnt = 4.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Bundles the pipeline request and data-memory signals seen by the MEM-stage access unit.
// The master side is the pipeline plus memory; the slave side is the access unit.
interface mem_access_unit_if;
   logic        req_read;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        flush;
   logic        dm_MemRead;
   logic        dm_MemWrite;
   logic [31:0] dm_addr;
   logic [31:0] dm_writeData;
   logic [31:0] dm_readData;
   logic [31:0] load_data;
   logic        stall;
   logic        misalign;

   modport master (
      output req_read, req_write, req_size, req_unsigned, req_addr, req_wdata, flush,
             dm_readData,
      input  dm_MemRead, dm_MemWrite, dm_addr, dm_writeData, load_data, stall, misalign
   );

   modport slave (
      input  req_read, req_write, req_size, req_unsigned, req_addr, req_wdata, flush,
             dm_readData,
      output dm_MemRead, dm_MemWrite, dm_addr, dm_writeData, load_data, stall, misalign
   );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage front end: byte/half/word loads with extension, sub-word stores as a
// two-cycle read-modify-write, and fault detection for misaligned or illegal requests.
module mem_access_unit #(
   parameter int unsigned COUNT_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   mem_access_unit_if.slave   bus,
   output logic [31:0]        bad_addr,
   output logic [COUNT_W-1:0] rmw_cnt,
   output logic [COUNT_W-1:0] fault_cnt
);

   typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

   localparam logic [COUNT_W-1:0] CntOne = {{(COUNT_W-1){1'b0}}, 1'b1};

   state_e             state_q, state_d;
   logic [31:0]        merge_q, merge_d;
   logic [31:0]        bad_addr_q, bad_addr_d;
   logic [COUNT_W-1:0] rmw_cnt_q, rmw_cnt_d;
   logic [COUNT_W-1:0] fault_cnt_q, fault_cnt_d;

   logic        active;
   logic        fault;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_ext;
   logic [31:0] merged;

   assign active = bus.req_read | bus.req_write;

   always_comb begin
      fault = 1'b0;
      if (active) begin
         fault = (bus.req_read & bus.req_write)
               | (bus.req_size == 2'b11)
               | ((bus.req_size == 2'b01) & bus.req_addr[0])
               | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00));
      end
   end

   // Little-endian lane extraction and extension for loads.
   always_comb begin
      byte_sel = bus.dm_readData[7:0];
      unique case (bus.req_addr[1:0])
         2'b00: byte_sel = bus.dm_readData[7:0];
         2'b01: byte_sel = bus.dm_readData[15:8];
         2'b10: byte_sel = bus.dm_readData[23:16];
         2'b11: byte_sel = bus.dm_readData[31:24];
         default: byte_sel = bus.dm_readData[7:0];
      endcase
      half_sel = bus.req_addr[1] ? bus.dm_readData[31:16] : bus.dm_readData[15:0];
      unique case (bus.req_size)
         2'b00:   load_ext = {{24{~bus.req_unsigned & byte_sel[7]}}, byte_sel};
         2'b01:   load_ext = {{16{~bus.req_unsigned & half_sel[15]}}, half_sel};
         default: load_ext = bus.dm_readData;
      endcase
   end

   // Old word with the target lane replaced; captured at the end of the RMW read cycle.
   always_comb begin
      merged = bus.dm_readData;
      if (bus.req_size == 2'b00) begin
         merged[{bus.req_addr[1:0], 3'b000} +: 8] = bus.req_wdata[7:0];
      end else begin
         merged[{bus.req_addr[1], 4'b0000} +: 16] = bus.req_wdata[15:0];
      end
   end

   assign bus.dm_addr = {bus.req_addr[31:2], 2'b00};

   always_comb begin
      state_d          = state_q;
      merge_d          = merge_q;
      bad_addr_d       = bad_addr_q;
      rmw_cnt_d        = rmw_cnt_q;
      fault_cnt_d      = fault_cnt_q;
      bus.dm_MemRead   = 1'b0;
      bus.dm_MemWrite  = 1'b0;
      bus.dm_writeData = 32'h0;
      bus.load_data    = 32'h0;
      bus.stall        = 1'b0;
      bus.misalign     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (active) begin
               if (fault) begin
                  bus.misalign = 1'b1;
                  bad_addr_d   = bus.req_addr;
                  if (fault_cnt_q != '1) fault_cnt_d = fault_cnt_q + CntOne;
               end else if (bus.req_read) begin
                  bus.dm_MemRead = 1'b1;
                  bus.load_data  = load_ext;
               end else if (bus.req_size == 2'b10) begin
                  bus.dm_MemWrite  = 1'b1;
                  bus.dm_writeData = bus.req_wdata;
               end else begin
                  bus.dm_MemRead = 1'b1;
                  bus.stall      = 1'b1;
                  merge_d        = merged;
                  state_d        = StRmwWr;
               end
            end
         end
         StRmwWr: begin
            state_d          = StIdle;
            bus.dm_writeData = merge_q;
            if (!bus.flush) begin
               bus.dm_MemWrite = 1'b1;
               if (rmw_cnt_q != '1) rmw_cnt_d = rmw_cnt_q + CntOne;
            end
         end
         default: state_d = StIdle;
      endcase
      // Strobes must be quiet while reset is held, including mid-RMW.
      if (reset) begin
         bus.dm_MemRead  = 1'b0;
         bus.dm_MemWrite = 1'b0;
         bus.stall       = 1'b0;
         bus.misalign    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StIdle;
         merge_q     <= 32'h0;
         bad_addr_q  <= 32'h0;
         rmw_cnt_q   <= '0;
         fault_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         merge_q     <= merge_d;
         bad_addr_q  <= bad_addr_d;
         rmw_cnt_q   <= rmw_cnt_d;
         fault_cnt_q <= fault_cnt_d;
      end
   end

   assign bad_addr  = bad_addr_q;
   assign rmw_cnt   = rmw_cnt_q;
   assign fault_cnt = fault_cnt_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 256x32 negedge-write data memory model.
module tb_mem_access_unit;

   logic        clk;
   logic        reset;
   logic [31:0] bad_addr;
   logic [15:0] rmw_cnt;
   logic [15:0] fault_cnt;
   logic [31:0] mem [256];
   int          n_tests;
   int          n_fail;
   int          stalls;

   mem_access_unit_if bus ();

   mem_access_unit #(.COUNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .bus       (bus.slave),
      .bad_addr  (bad_addr),
      .rmw_cnt   (rmw_cnt),
      .fault_cnt (fault_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.dm_MemWrite) mem[bus.dm_addr[9:2]] <= bus.dm_writeData;
   end
   assign bus.dm_readData = bus.dm_MemRead ? mem[bus.dm_addr[9:2]] : 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd);
      bus.req_read     = rd;
      bus.req_write    = wr;
      bus.req_size     = sz;
      bus.req_unsigned = uns;
      bus.req_addr     = a;
      bus.req_wdata    = wd;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      stalls    = 0;
      bus.flush = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h08] = 32'h1122_3344;
      mem[8'h0C] = 32'h80F0_7F01;
      mem[8'h10] = 32'hCAFE_F00D;
      mem[8'h14] = 32'h1234_5678;
      mem[8'h18] = 32'hFFFF_FFFF;

      // Reset with a request pending: strobes stay low.
      reset = 1'b1;
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      #4;
      check("rst_memread", {31'b0, bus.dm_MemRead}, 32'h0);
      check("rst_stall", {31'b0, bus.stall}, 32'h0);
      tick();
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      #3;
      check("rst_bad_addr", bad_addr, 32'h0);
      check("rst_rmw_cnt", {16'b0, rmw_cnt}, 32'h0);
      check("rst_fault_cnt", {16'b0, fault_cnt}, 32'h0);
      check("idle_load_data", bus.load_data, 32'h0);
      check("idle_memread", {31'b0, bus.dm_MemRead}, 32'h0);
      tick();

      // Word store then word load.
      drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
      #3;
      check("sw_memwrite", {31'b0, bus.dm_MemWrite}, 32'h1);
      check("sw_wdata", bus.dm_writeData, 32'hDEAD_BEEF);
      check("sw_stall", {31'b0, bus.stall}, 32'h0);
      tick();
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      #3;
      check("lw_memwrite", {31'b0, bus.dm_MemWrite}, 32'h0);
      check("lw_memread", {31'b0, bus.dm_MemRead}, 32'h1);
      check("lw_data", bus.load_data, 32'hDEAD_BEEF);
      tick();

      // Byte store RMW: only the low byte of wdata lands in lane 2.
      drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h22, 32'hFFFF_FFAB);
      #3;
      check("sb_dm_addr", bus.dm_addr, 32'h20);
      check("sb_rd_stall", {31'b0, bus.stall}, 32'h1);
      check("sb_rd_memread", {31'b0, bus.dm_MemRead}, 32'h1);
      check("sb_rd_memwrite", {31'b0, bus.dm_MemWrite}, 32'h0);
      tick();
      #3;
      check("sb_wr_stall", {31'b0, bus.stall}, 32'h0);
      check("sb_wr_memwrite", {31'b0, bus.dm_MemWrite}, 32'h1);
      check("sb_wr_data", bus.dm_writeData, 32'h11AB_3344);
      tick();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      #3;
      check("sb_mem", mem[8'h08], 32'h11AB_3344);
      check("sb_rmw_cnt", {16'b0, rmw_cnt}, 32'h1);
      check("sb_after_memwrite", {31'b0, bus.dm_MemWrite}, 32'h0);
      tick();

      // Sign and zero extension.
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h32, 32'h0);
      #3;
      check("lb_32", bus.load_data, 32'hFFFF_FFF0);
      tick();
      drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h32, 32'h0);
      #3;
      check("lbu_32", bus.load_data, 32'h0000_00F0);
      tick();
      drive(1'b1, 1'b0, 2'b01, 1'b0, 32'h32, 32'h0);
      #3;
      check("lh_32", bus.load_data, 32'hFFFF_80F0);
      tick();
      drive(1'b1, 1'b0, 2'b01, 1'b1, 32'h30, 32'h0);
      #3;
      check("lhu_30", bus.load_data, 32'h0000_7F01);
      tick();
      drive(1'b1, 1'b0, 2'b00, 1'b0, 32'h31, 32'h0);
      #3;
      check("lb_31", bus.load_data, 32'h0000_007F);
      tick();

      // Faults: misaligned word load, misaligned half store, illegal size.
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h41, 32'h0);
      #3;
      check("lw41_misalign", {31'b0, bus.misalign}, 32'h1);
      check("lw41_memread", {31'b0, bus.dm_MemRead}, 32'h0);
      check("lw41_load_data", bus.load_data, 32'h0);
      tick();
      check("lw41_bad_addr", bad_addr, 32'h41);
      check("lw41_fault_cnt", {16'b0, fault_cnt}, 32'h1);
      drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h43, 32'h5555);
      #3;
      check("sh43_misalign", {31'b0, bus.misalign}, 32'h1);
      check("sh43_memwrite", {31'b0, bus.dm_MemWrite}, 32'h0);
      check("sh43_stall", {31'b0, bus.stall}, 32'h0);
      tick();
      check("sh43_bad_addr", bad_addr, 32'h43);
      check("sh43_fault_cnt", {16'b0, fault_cnt}, 32'h2);
      drive(1'b1, 1'b0, 2'b11, 1'b0, 32'h44, 32'h0);
      #3;
      check("sz11_misalign", {31'b0, bus.misalign}, 32'h1);
      tick();
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      #3;
      check("sz11_fault_cnt", {16'b0, fault_cnt}, 32'h3);
      check("sz11_bad_addr", bad_addr, 32'h44);
      check("sh43_mem", mem[8'h10], 32'hCAFE_F00D);
      tick();

      // Flush during RMW_WR suppresses the write.
      drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h50, 32'hBEEF);
      #3;
      check("shfl_stall", {31'b0, bus.stall}, 32'h1);
      tick();
      bus.flush = 1'b1;
      #3;
      check("shfl_memwrite", {31'b0, bus.dm_MemWrite}, 32'h0);
      tick();
      bus.flush = 1'b0;
      drive(1'b1, 1'b0, 2'b00, 1'b1, 32'h50, 32'h0);
      #3;
      check("shfl_next_idle", bus.load_data, 32'h0000_0078);
      check("shfl_next_stall", {31'b0, bus.stall}, 32'h0);
      check("shfl_rmw_cnt", {16'b0, rmw_cnt}, 32'h1);
      check("shfl_mem", mem[8'h14], 32'h1234_5678);
      tick();

      // Reset during RMW_WR suppresses the write and clears all state.
      drive(1'b0, 1'b1, 2'b01, 1'b0, 32'h52, 32'hBEEF);
      #3;
      check("shrst_stall", {31'b0, bus.stall}, 32'h1);
      tick();
      reset = 1'b1;
      #3;
      check("shrst_memwrite", {31'b0, bus.dm_MemWrite}, 32'h0);
      tick();
      reset = 1'b0;
      drive(1'b1, 1'b0, 2'b10, 1'b0, 32'h50, 32'h0);
      #3;
      check("shrst_rmw_cnt", {16'b0, rmw_cnt}, 32'h0);
      check("shrst_fault_cnt", {16'b0, fault_cnt}, 32'h0);
      check("shrst_bad_addr", bad_addr, 32'h0);
      check("shrst_load", bus.load_data, 32'h1234_5678);
      check("shrst_stall", {31'b0, bus.stall}, 32'h0);
      tick();

      // Back-to-back byte stores into one word.
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b1, 2'b00, 1'b0, 32'h60 + 32'(i), 32'(i + 1));
         #3;
         stalls += int'(bus.stall);
         tick();
         #3;
         stalls += int'(bus.stall);
         tick();
      end
      drive(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
      #3;
      check("b2b_stalls", 32'(stalls), 32'h4);
      check("b2b_mem", mem[8'h18], 32'h0403_0201);
      check("b2b_rmw_cnt", {16'b0, rmw_cnt}, 32'h4);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
